// File: rtl/id_ex_control_stage.sv
// -----------------------------------------------------------------------------
// common_pkg / id_ex_control_stage
//
// Purpose: ID/EX pipeline register for the decoded control word. Detects the
// classic load-use hazard (load in execute, dependent instruction in decode),
// stalls the front end for one cycle while inserting a bubble, and squashes
// the decoding instruction when execute redirects the PC. Two saturating
// counters record how many stall and flush events have occurred.
//
// Ports:
//   clk              rising-edge clock
//   reset_n          asynchronous active-low reset
//   control_in       decoded control word from the decoder
//   valid_in         decode-side fields hold a real instruction
//   rs1_in, rs2_in   source register indices of the decoding instruction
//   rd_in            destination register index of the decoding instruction
//   flush_in         branch/jump taken in execute; squash decode
//   control_out      registered control word to execute
//   valid_out        control_out holds a real instruction
//   rd_out           registered destination index
//   stall_out        combinational: hold PC and IF/ID this cycle
//   stall_count_out  saturating count of load-use stalls
//   flush_count_out  saturating count of flush cycles
// -----------------------------------------------------------------------------
package common_pkg;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [3:0] alu_op;
  } control_type;
endpackage

module id_ex_control_stage
  import common_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  control_type       control_in,
  input  logic              valid_in,
  input  logic [4:0]        rs1_in,
  input  logic [4:0]        rs2_in,
  input  logic [4:0]        rd_in,
  input  logic              flush_in,
  output control_type       control_out,
  output logic              valid_out,
  output logic [4:0]        rd_out,
  output logic              stall_out,
  output logic [CNT_W-1:0]  stall_count_out,
  output logic [CNT_W-1:0]  flush_count_out
);

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  control_type        ctrl_q, ctrl_d;
  logic               vld_q, vld_d;
  logic [4:0]         rd_q, rd_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic               hazard;
  logic               take_bubble;
  logic               accept;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  // Load in execute whose destination is read by the decoding instruction.
  // x0 is never a real producer. Both sources are compared regardless of
  // whether the instruction actually uses them (conservative stall).
  assign hazard = vld_q && ctrl_q.mem_read && (rd_q != 5'd0) && valid_in &&
                  ((rd_q == rs1_in) || (rd_q == rs2_in));

  // A flush already squashes the decoding instruction, so stalling it would
  // only lose the redirected fetch.
  assign stall_out   = hazard && !flush_in;
  assign take_bubble = flush_in || hazard;
  assign accept      = !take_bubble && valid_in;

  always_comb begin
    ctrl_d      = '0;
    vld_d       = 1'b0;
    rd_d        = 5'd0;
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (accept) begin
      ctrl_d = control_in;
      vld_d  = 1'b1;
      rd_d   = rd_in;
    end

    if (take_bubble) begin
      state_d = BUBBLE;
    end else if (accept) begin
      state_d = RUN;
    end

    if (stall_out) stall_cnt_d = sat_inc(stall_cnt_q);
    if (flush_in)  flush_cnt_d = sat_inc(flush_cnt_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      ctrl_q      <= '0;
      vld_q       <= 1'b0;
      rd_q        <= 5'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      vld_q       <= vld_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign control_out     = ctrl_q;
  assign valid_out       = vld_q;
  assign rd_out          = rd_q;
  assign stall_count_out = stall_cnt_q;
  assign flush_count_out = flush_cnt_q;

  // BUBBLE is only ever entered or held by loading a bubble, so it can never
  // coexist with a valid output; and a stall needs a valid load in execute.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(state_q == BUBBLE && vld_q))
        else $error("BUBBLE state with valid_out set");
      assert (!(stall_out && state_q != RUN))
        else $error("stall raised outside RUN state");
    end
  end

endmodule

// File: tb/tb_id_ex_control_stage.sv
module tb_id_ex_control_stage;
  import common_pkg::*;

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic              clk;
  logic              reset_n;
  control_type       control_in;
  logic              valid_in;
  logic [4:0]        rs1_in, rs2_in, rd_in;
  logic              flush_in;
  control_type       control_out;
  logic              valid_out;
  logic [4:0]        rd_out;
  logic              stall_out;
  logic [CNT_W-1:0]  stall_count_out, flush_count_out;

  id_ex_control_stage #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .control_in      (control_in),
    .valid_in        (valid_in),
    .rs1_in          (rs1_in),
    .rs2_in          (rs2_in),
    .rd_in           (rd_in),
    .flush_in        (flush_in),
    .control_out     (control_out),
    .valid_out       (valid_out),
    .rd_out          (rd_out),
    .stall_out       (stall_out),
    .stall_count_out (stall_count_out),
    .flush_count_out (flush_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what the execute stage currently holds, plus event tallies.
  control_type m_ctrl;
  logic        m_vld;
  logic [4:0]  m_rd;
  int          m_stalls;
  int          m_flushes;
  logic        last_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int n);
    return (n > int'(CMAX)) ? 32'(CMAX) : 32'(n);
  endfunction

  task automatic model_reset();
    m_ctrl    = '0;
    m_vld     = 1'b0;
    m_rd      = 5'd0;
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  // One cycle: drive at negedge, check stall before the edge, apply the
  // model's action at the edge, check registered outputs after it.
  task automatic step(input control_type c, input logic v, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [4:0] rd, input logic fl);
    logic haz, exp_stall;
    control_type c_use;
    control_in = c; valid_in = v; rs1_in = r1; rs2_in = r2; rd_in = rd; flush_in = fl;
    #1;
    haz = m_vld && m_ctrl.mem_read && m_rd != 0 && v && (m_rd == r1 || m_rd == r2);
    exp_stall = haz && !fl;
    last_stall = stall_out;
    chk("stall_out", 32'(stall_out), 32'(exp_stall));
    @(posedge clk);
    if (fl) m_flushes++;
    if (exp_stall) m_stalls++;
    c_use = c;
    if (fl || haz || !v) begin
      m_ctrl = '0; m_vld = 1'b0; m_rd = 5'd0;
    end else begin
      m_ctrl = c_use; m_vld = 1'b1; m_rd = rd;
    end
    #1;
    chk("control_out", 32'(control_out), 32'(m_ctrl));
    chk("valid_out", 32'(valid_out), 32'(m_vld));
    chk("rd_out", 32'(rd_out), 32'(m_rd));
    chk("stall_count", 32'(stall_count_out), sat(m_stalls));
    chk("flush_count", 32'(flush_count_out), sat(m_flushes));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  control_type c_alu, c_load, c_zero;
  logic [9:0]  rbits;
  logic [1:0]  fc_exp [5];

  initial begin
    c_zero = '0;
    c_alu = '0;  c_alu.reg_write = 1'b1;  c_alu.alu_op = 4'h3;
    c_load = '0; c_load.reg_write = 1'b1; c_load.mem_read = 1'b1; c_load.alu_src = 1'b1;
    control_in = '0; valid_in = 0; rs1_in = 0; rs2_in = 0; rd_in = 0; flush_in = 0;
    last_stall = 1'b0;
    model_reset();

    // Reset values, held asynchronously before any edge.
    reset_n = 1'b0;
    #1;
    chk("rst_ctrl", 32'(control_out), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_scnt", 32'(stall_count_out), 32'd0);
    chk("rst_fcnt", 32'(flush_count_out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Normal flow.
    step(c_alu, 1, 5'd1, 5'd2, 5'd5, 0);
    chk("norm_valid", 32'(valid_out), 32'd1);
    chk("norm_rd", 32'(rd_out), 32'd5);
    chk("norm_regw", 32'(control_out.reg_write), 32'd1);
    chk("norm_stall", 32'(stall_out), 32'd0);

    // Load-use: one-cycle stall, bubble, then the dependent instruction.
    do_reset();
    step(c_load, 1, 5'd1, 5'd2, 5'd7, 0);
    step(c_alu, 1, 5'd7, 5'd3, 5'd8, 0);
    chk("lu_stall", 32'(last_stall), 32'd1);
    chk("lu_bubble", 32'(valid_out), 32'd0);
    chk("lu_scnt", 32'(stall_count_out), 32'd1);
    step(c_alu, 1, 5'd7, 5'd3, 5'd8, 0);
    chk("lu_stall2", 32'(last_stall), 32'd0);
    chk("lu_dep_valid", 32'(valid_out), 32'd1);
    chk("lu_dep_rd", 32'(rd_out), 32'd8);

    // Load to x0 never stalls.
    do_reset();
    step(c_load, 1, 5'd1, 5'd2, 5'd0, 0);
    step(c_alu, 1, 5'd0, 5'd0, 5'd4, 0);
    chk("x0_stall", 32'(last_stall), 32'd0);
    chk("x0_valid", 32'(valid_out), 32'd1);
    chk("x0_scnt", 32'(stall_count_out), 32'd0);

    // Flush and hazard together count as a flush only.
    do_reset();
    step(c_load, 1, 5'd1, 5'd2, 5'd7, 0);
    step(c_alu, 1, 5'd7, 5'd3, 5'd8, 1);
    chk("fh_stall", 32'(last_stall), 32'd0);
    chk("fh_valid", 32'(valid_out), 32'd0);
    chk("fh_fcnt", 32'(flush_count_out), 32'd1);
    chk("fh_scnt", 32'(stall_count_out), 32'd0);

    // Saturation with a 2-bit counter.
    do_reset();
    fc_exp[0] = 2'd1; fc_exp[1] = 2'd2; fc_exp[2] = 2'd3; fc_exp[3] = 2'd3; fc_exp[4] = 2'd3;
    for (int i = 0; i < 5; i++) begin
      step(c_alu, 1, 5'd1, 5'd2, 5'd3, 1);
      chk($sformatf("sat_%0d", i), 32'(flush_count_out), 32'(fc_exp[i]));
    end

    // Reset dropped mid-stall, between edges.
    do_reset();
    step(c_load, 1, 5'd1, 5'd2, 5'd7, 0);
    control_in = c_alu; valid_in = 1; rs1_in = 5'd7; rs2_in = 5'd3; rd_in = 5'd9; flush_in = 0;
    #1;
    chk("rms_stall_pre", 32'(stall_out), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rms_valid", 32'(valid_out), 32'd0);
    chk("rms_ctrl", 32'(control_out), 32'd0);
    chk("rms_stall", 32'(stall_out), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(c_alu, 1, 5'd7, 5'd3, 5'd9, 0);
    chk("rms_after_valid", 32'(valid_out), 32'd1);
    chk("rms_after_rd", 32'(rd_out), 32'd9);

    // Randomized traffic against the model; small register range to provoke hazards.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      control_type rc;
      rbits = 10'($urandom);
      rc = rbits;
      step(rc, ($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0));
      if (i == 200) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
